spi_cmd_decoder: RTL and testbench

- Sits directly downstream of the SPI slave byte receiver.
- Consumes its received-byte stream and parses it into framed commands.
- Commits decoded writes to a bank of 16-bit configuration registers, such as mixer mode, opacity and offsets, which the video pipeline reads continuously.
- Packets are framed by slave select; partial packets are discarded.

---
 rtl/spi_cmd_decoder.sv | 120 ++++++++++++
 tb/tb_spi_cmd_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_cmd_decoder: parses SPI byte stream into register writes / bank clear. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_cmd_decoder #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_active,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic [NUM_REGS*16-1:0] regs_flat,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [15:0]            wr_data,
    output logic                   clr_pulse,
    output logic [7:0]             err_count,
    output logic                   busy
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_wait_lo = 2'd1;
    localparam logic [1:0] c_wait_hi = 2'd2;

    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_hi;

    logic        w_take;
    logic        w_abort;
    logic        w_clear;
    logic        w_commit;
    logic        w_addr_ok;
    logic        w_wr;
    logic        w_err;
    logic [15:0] w_data;

    // A byte seen while the frame is down is never decoded.
    assign w_take    = byte_valid & frame_active;
    assign w_abort   = (r_state != c_idle) & ~frame_active;
    assign w_clear   = w_take & (r_state == c_idle) & (byte_in[7:6] == 2'b11);
    assign w_commit  = w_take & (r_state == c_wait_lo);
    assign w_addr_ok = ({1'b0, r_addr} < c_num_regs);
    assign w_wr      = w_commit & w_addr_ok;
    assign w_err     = w_abort | (w_commit & ~w_addr_ok);
    assign w_data    = {r_hi, byte_in};
    assign busy      = (r_state != c_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_addr    <= '0;
            r_hi      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            clr_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            wr_en     <= w_wr;
            clr_pulse <= w_clear;
            if (w_wr) begin
                wr_addr <= r_addr;
                wr_data <= w_data;
            end
            if (w_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (w_abort) begin
                r_state <= c_idle;
            end else if (w_take) begin
                case (r_state)
                    c_idle: begin
                        case (byte_in[7:6])
                            2'b01: begin
                                // High byte zeroed so WRITE8 data is zero-extended.
                                r_addr  <= byte_in[ADDR_W-1:0];
                                r_hi    <= 8'h00;
                                r_state <= c_wait_lo;
                            end
                            2'b10: begin
                                r_addr  <= byte_in[ADDR_W-1:0];
                                r_state <= c_wait_hi;
                            end
                            default: r_state <= c_idle;
                        endcase
                    end
                    c_wait_hi: begin
                        r_hi    <= byte_in;
                        r_state <= c_wait_lo;
                    end
                    c_wait_lo: r_state <= c_idle;
                    default:   r_state <= c_idle;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        logic [15:0] r_reg;

        always_ff @(posedge clk) begin
            if (rst || w_clear) begin
                r_reg <= '0;
            end else if (w_wr && (r_addr == ADDR_W'(i))) begin
                r_reg <= w_data;
            end
        end

        assign regs_flat[16*i +: 16] = r_reg;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
// Self-checking bench for spi_cmd_decoder; expected writes flow through a scoreboard queue.
module tb_spi_cmd_decoder;

    localparam int NUM_REGS = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   frame_active;
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic [NUM_REGS*16-1:0] regs_flat;
    logic                   wr_en;
    logic [5:0]             wr_addr;
    logic [15:0]            wr_data;
    logic                   clr_pulse;
    logic [7:0]             err_count;
    logic                   busy;

    spi_cmd_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .frame_active(frame_active), .byte_in(byte_in),
        .byte_valid(byte_valid), .regs_flat(regs_flat), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_pulse(clr_pulse),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [21:0] sb_q[$];
    logic [15:0] exp_regs[NUM_REGS];
    int          exp_err    = 0;
    int          exp_wr_cnt = 0;
    int          wr_cnt     = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[16*i +: 16] = exp_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 16'h0;
        exp_err = 0;
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    // Called at a negedge; returns at the negedge after the sampling posedge.
    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic expect_commit(input logic [5:0] addr, input logic [15:0] data);
        if (addr < NUM_REGS) begin
            sb_q.push_back({addr, data});
            exp_regs[addr] = data;
            exp_wr_cnt++;
        end else begin
            bump_err();
        end
    endtask

    task automatic do_write8(input logic [5:0] addr, input logic [7:0] data);
        send_byte({2'b01, addr});
        expect_commit(addr, {8'h00, data});
        send_byte(data);
        check("w8_wr_en", 256'(wr_en), 256'(addr < NUM_REGS));
        check("w8_err", 256'(err_count), 256'(exp_err));
    endtask

    task automatic do_write16(input logic [5:0] addr, input logic [15:0] data);
        send_byte({2'b10, addr});
        send_byte(data[15:8]);
        expect_commit(addr, data);
        send_byte(data[7:0]);
        check("w16_wr_en", 256'(wr_en), 256'(addr < NUM_REGS));
    endtask

    // Scoreboard consumer: every wr_en pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_wr", 256'(wr_en), 256'(0));
            end else begin
                logic [21:0] e;
                e = sb_q.pop_front();
                check("sb_wr_addr", 256'(wr_addr), 256'(e[21:16]));
                check("sb_wr_data", 256'(wr_data), 256'(e[15:0]));
                check("sb_reg_val", 256'(regs_flat[16*wr_addr +: 16]), 256'(e[15:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; frame_active = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_regs", regs_flat, 256'(0));
        check("rst_outs", {wr_en, clr_pulse, busy, wr_addr, wr_data, err_count}, 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // WRITE8 to reg 3
        frame_active = 1'b1;
        do_write8(6'd3, 8'hA5);
        check("w8_regs", regs_flat, model_flat());
        @(negedge clk);
        check("wr_en_single", 256'(wr_en), 256'(0));

        // WRITE16 then WRITE8 back-to-back in one frame
        do_write16(6'd1, 16'h1234);
        check("w16_regs", regs_flat, model_flat());
        do_write8(6'd1, 8'h07);
        check("b2b_regs", regs_flat, model_flat());
        frame_active = 1'b0;
        @(negedge clk);

        // Frame abort mid WRITE16
        frame_active = 1'b1;
        send_byte(8'h85);
        send_byte(8'hBE);
        check("abort_busy_before", 256'(busy), 256'(1));
        frame_active = 1'b0;
        bump_err();
        @(negedge clk);
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_err", 256'(err_count), 256'(exp_err));
        check("abort_regs", regs_flat, model_flat());
        frame_active = 1'b1;
        do_write8(6'd5, 8'h11);
        check("after_abort_regs", regs_flat, model_flat());

        // Invalid address
        do_write8(6'h3F, 8'h99);
        check("inv_regs", regs_flat, model_flat());

        // Byte while frame down in IDLE is ignored; in WAIT it aborts
        frame_active = 1'b0;
        send_byte(8'h43);
        check("idle_ignore_busy", 256'(busy), 256'(0));
        check("idle_ignore_err", 256'(err_count), 256'(exp_err));
        frame_active = 1'b1;
        send_byte(8'h81);
        frame_active = 1'b0;
        bump_err();
        send_byte(8'h12);
        check("sim_abort_err", 256'(err_count), 256'(exp_err));
        check("sim_abort_busy", 256'(busy), 256'(0));
        check("sim_abort_regs", regs_flat, model_flat());

        // CLEAR
        frame_active = 1'b1;
        do_write16(6'd15, 16'hCAFE);
        do_write8(6'd0, 8'h5A);
        check("pre_clear_regs", regs_flat, model_flat());
        send_byte(8'hC0);
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 16'h0;
        check("clr_pulse", 256'(clr_pulse), 256'(1));
        check("clr_regs", regs_flat, model_flat());
        check("clr_err_kept", 256'(err_count), 256'(exp_err));
        @(negedge clk);
        check("clr_single", 256'(clr_pulse), 256'(0));

        // NOP does nothing
        send_byte(8'h07);
        check("nop_busy", 256'(busy), 256'(0));
        check("nop_wr_en", 256'(wr_en), 256'(0));

        // Reset mid WRITE16
        do_write8(6'd9, 8'h33);
        send_byte(8'h82);
        send_byte(8'h55);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_regs", regs_flat, 256'(0));
        check("midrst_outs", {wr_en, clr_pulse, busy, wr_addr, wr_data, err_count}, 256'(0));
        do_write16(6'd2, 16'hBEEF);
        check("post_rst_regs", regs_flat, model_flat());

        // Error counter saturation
        for (int i = 0; i < 260; i++) do_write8(6'h30, 8'(i));
        check("err_sat", 256'(err_count), 256'(255));
        do_write8(6'h20, 8'h01);
        check("err_hold", 256'(err_count), 256'(255));
        check("sat_regs", regs_flat, model_flat());

        repeat (2) @(negedge clk);
        check("sb_empty", 256'(sb_q.size()), 256'(0));
        check("wr_pulse_count", 256'(wr_cnt), 256'(exp_wr_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
